// File: rtl/sign_pkg.sv
// Shared types and helpers for the sign stream classifier.
package sign_pkg;

  // Widest sample the magnitude helper supports; callers sign-extend into it.
  localparam int MAG_W = 64;

  typedef enum logic [1:0] {
    H_NONE = 2'd0,
    H_POS  = 2'd1,
    H_NEG  = 2'd2
  } hist_state_t;

  // Absolute value of a sign-extended two's-complement sample. Because the
  // input is extended to MAG_W bits, the most negative WIDTH-bit value maps
  // to 2^(WIDTH-1) without overflowing once sliced back to WIDTH bits.
  function automatic logic [MAG_W-1:0] abs_mag(input logic [MAG_W-1:0] v);
    return v[MAG_W-1] ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. A clear coincident with an
// increment leaves the counter at 1 (clear first, then count).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  // Count register: reset, clear-then-increment, or hold at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= inc ? CNT_W'(1) : '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sign_stream_classifier.sv
// Streaming sign classifier: one output register behind a valid/ready
// handshake, a history FSM for zero-crossing detection and three
// saturating statistics counters.
//
// History FSM states
//   state  | meaning
//   H_NONE | no nonzero sample seen since reset/clr
//   H_POS  | last nonzero accepted sample was positive
//   H_NEG  | last nonzero accepted sample was negative
module sign_stream_classifier
  import sign_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_xing,
  output logic [CNT_W-1:0] pos_cnt,
  output logic [CNT_W-1:0] neg_cnt,
  output logic [CNT_W-1:0] zero_cnt
);

  logic             accept;
  logic             samp_neg;
  logic             samp_zero;
  logic [MAG_W-1:0] samp_ext;
  logic [MAG_W-1:0] mag_full;
  logic [WIDTH-1:0] samp_mag;
  logic             unused_mag_hi;

  logic             out_valid_q;
  logic             out_sign_q;
  logic             out_zero_q;
  logic [WIDTH-1:0] out_mag_q;
  logic             out_xing_q;

  hist_state_t      hist_q;
  hist_state_t      hist_d;
  hist_state_t      hist_eff;
  logic             xing_d;

  // Single output stage: room for a new sample when empty or draining.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  assign samp_neg  = in_data[WIDTH-1];
  assign samp_zero = (in_data == '0);
  assign samp_ext  = {{(MAG_W-WIDTH){in_data[WIDTH-1]}}, in_data};
  assign mag_full  = abs_mag(samp_ext);
  assign samp_mag  = mag_full[WIDTH-1:0];
  // Upper bits are sign-extension residue and always zero for |x| <= 2^(WIDTH-1).
  assign unused_mag_hi = ^mag_full[MAG_W-1:WIDTH];

  // History state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q <= H_NONE;
    end else begin
      hist_q <= hist_d;
    end
  end

  // Next history state and crossing flag; clr is seen before the sample.
  always_comb begin
    hist_eff = clr ? H_NONE : hist_q;
    hist_d   = hist_eff;
    xing_d   = 1'b0;
    if (accept && !samp_zero) begin
      xing_d = ((hist_eff == H_POS) && samp_neg) ||
               ((hist_eff == H_NEG) && !samp_neg);
      hist_d = samp_neg ? H_NEG : H_POS;
    end
  end

  // Output register: load on accept, drop valid when drained without refill.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_zero_q  <= 1'b0;
      out_mag_q   <= '0;
      out_xing_q  <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_sign_q  <= samp_neg;
      out_zero_q  <= samp_zero;
      out_mag_q   <= samp_mag;
      out_xing_q  <= xing_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sign  = out_sign_q;
  assign out_zero  = out_zero_q;
  assign out_mag   = out_mag_q;
  assign out_xing  = out_xing_q;

  sat_counter #(.CNT_W(CNT_W)) u_pos_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (accept && !samp_zero && !samp_neg),
    .count (pos_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_neg_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (accept && samp_neg),
    .count (neg_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_zero_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (accept && samp_zero),
    .count (zero_cnt)
  );

endmodule
